alg_apb_responder: RTL

- APB completer (responder) model for the DCD Allegro testbench. It terminates the initiator-side APB bus that the two-port APB arbiter drives.
- Contains a word-addressed register bank with a read-only ID word and a programmable number of wait states.
- Out-of-range accesses get a fixed read-back pattern, and an error counter tracks them.
- Registered outputs only. Exactly one s_ready pulse per transfer.

---
 rtl/alg_apb_pkg.sv | 14 +
 rtl/alg_apb_regbank.sv | 37 +++
 rtl/alg_apb_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alg_apb_pkg.sv
// Shared types and constants for the Allegro APB responder.
// Holds the FSM encoding and the out-of-range read-back pattern.
package alg_apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } apb_rsp_state_e;

  localparam logic [31:0] APB_OOR_RDATA = 32'hDEAD_BEEF;
  localparam int unsigned APB_ERR_CNT_W = 8;

endpackage

// File: rtl/alg_apb_regbank.sv
// Word register bank behind the APB responder.
// Word 0 is a read-only ID; words 1..NUM_REGS-1 are read/write.
module alg_apb_regbank #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA16_0001,
  localparam int unsigned IW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [NUM_REGS];
  logic [31:0] mem_d [NUM_REGS];

  // Word 0 storage is never written, so the ID stays constant
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (idx != '0)) begin
      mem_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = (idx == '0) ? ID_VALUE : mem_q[idx];

endmodule

// File: rtl/alg_apb_responder.sv
// APB completer with programmable wait states and an ID word.
// Out-of-range accesses read DEAD_BEEF and bump a saturating counter.
module alg_apb_responder
  import alg_apb_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 22,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [31:0]          ID_VALUE   = 32'hA16_0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    s_addr,
  input  logic                     s_sel,
  input  logic                     s_enable,
  input  logic                     s_write,
  input  logic [31:0]              s_wdata,
  output logic [31:0]              s_rdata,
  output logic                     s_ready,
  input  logic [3:0]               wait_cfg,
  output logic [APB_ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * 4);

  apb_rsp_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic           inr_q, inr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           ready_q, ready_d;
  logic [APB_ERR_CNT_W-1:0] err_q, err_d;

  logic [ADDR_WIDTH-1:0] off;
  logic          bus_inr;
  logic [IW-1:0] bus_idx;
  logic          idle;
  logic          cur_wr;
  logic          cur_inr;
  logic [IW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic          complete;
  logic [31:0]   rb_rdata;

  assign off     = s_addr - BASE_ADDR;
  assign bus_inr = off < SPAN;
  assign bus_idx = off[2 +: IW];

  // A zero-wait transfer completes on its start edge, so use live bus values
  assign idle      = (state_q == S_IDLE);
  assign cur_wr    = idle ? s_write : wr_q;
  assign cur_inr   = idle ? bus_inr : inr_q;
  assign cur_idx   = idle ? bus_idx : idx_q;
  assign cur_wdata = idle ? s_wdata : wdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    inr_d    = inr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_sel && s_enable) begin
          wr_d    = s_write;
          inr_d   = bus_inr;
          idx_d   = bus_idx;
          wdata_d = s_wdata;
          if (wait_cfg == 4'd0) begin
            complete = 1'b1;
            state_d  = S_RESP;
          end else begin
            cnt_d   = wait_cfg;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d    = 4'd0;
          complete = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (complete) begin
      ready_d = 1'b1;
      if (cur_wr) begin
        rdata_d = '0;
      end else if (!cur_inr) begin
        rdata_d = APB_OOR_RDATA;
      end else begin
        rdata_d = rb_rdata;
      end
      if (!cur_inr && (err_q != '1)) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      inr_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      inr_q   <= inr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  alg_apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .clk   (clk),
    .rst   (rst),
    .wr_en (complete && cur_wr && cur_inr),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (rb_rdata)
  );

  assign s_rdata = rdata_q;
  assign s_ready = ready_q;
  assign err_cnt = err_q;

endmodule
